mix_columns: RTL and testbench
==============================

# mix_columns

Registered AES MixColumns stage. It treats a 128-bit AES state as four independent 32-bit columns. Each column is multiplied by the fixed GF(2^8) matrix of FIPS-197 §5.1.3. The result is presented one clock after a valid input. It sits in the AES round datapath between ShiftRows and AddRoundKey, and is bypassed by the round controller in the final round.

## Interface
Parameters:
- none; state width is fixed at 128 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  `in` is valid this cycle.
- in  in  [0:127]  state; bit 0 is the MSB; byte k = in[8k:8k+7]; column c = bytes 4c..4c+3, holding rows 0..3.
- inv  in  1  selects InvMixColumns; exists only when MIX_COLUMNS_INV_EN is defined.
- out_valid  out  1  `out` holds a result this cycle.
- out  out  [0:127]  transformed state, same byte layout as `in`.

## Operation
- Per column (a0,a1,a2,a3) → (b0,b1,b2,b3), with all arithmetic in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B):
  - b0 = 2·a0 ⊕ 3·a1 ⊕ a2 ⊕ a3
  - b1 = a0 ⊕ 2·a1 ⊕ 3·a2 ⊕ a3
  - b2 = a0 ⊕ a1 ⊕ 2·a2 ⊕ 3·a3
  - b3 = 3·a0 ⊕ a1 ⊕ a2 ⊕ 2·a3
- xtime(x) = (x<<1)[7:0] ⊕ (x[7] ? 0x1B : 0x00).
- 3·x = xtime(x) ⊕ x.
- Four identical column units, purely combinational, feeding a single output register.
- No state beyond the output register and the valid flag; columns are fully independent.
- Any 128-bit input is legal; there are no illegal values.

## Timing
- Latency is exactly 1 cycle. If in_valid=1 at edge N, then after edge N: out = MixColumns(in) and out_valid = 1.
- in_valid=0 at an edge: out_valid ← 0; `out` holds its previous value.
- Back-to-back: one result per cycle, with no stalls and no backpressure.
- reset=1 at an edge: out ← 128'h0 and out_valid ← 0, regardless of in_valid.
- Reset asserted mid-stream discards the in-flight result.
- The first valid input after reset deasserts produces its output one cycle later.
- `inv` is sampled on the same edge as `in`.

## Configuration
- MIX_COLUMNS_INV_EN defined:
  - `inv` port present.
  - inv=1 applies InvMixColumns using matrix rows {0E,0B,0D,09}, {09,0E,0B,0D}, {0D,09,0E,0B}, {0B,0D,09,0E}. Each row is applied to (a0..a3) in the same pattern as the forward matrix.
  - Multiples are built from chained xtime: 9=8⊕1, B=8⊕2⊕1, D=8⊕4⊕1, E=8⊕4⊕2.
  - inv=0 applies the forward transform.
  - Latency is unchanged.
- MIX_COLUMNS_INV_EN undefined: no `inv` port; forward transform only.

## Test plan
- Reset: hold reset=1 for 2 cycles with in_valid=1 and arbitrary `in` → out=0 and out_valid=0. Release reset → out_valid rises one cycle after the first in_valid.
- FIPS-197 round-1 vector: in=d4bf5d30_e0b452ae_b84111f1_1e2798e5 → out=046681e5_e0cb199a_48f8d37a_2806264c, one cycle later.
- Standard columns, applied back-to-back on consecutive cycles:
  - in=db135345_f20a225c_01010101_c6c6c6c6 → out=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - in=d4d4d4d5_2d26314c_00000000_ffffffff → out=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - out_valid must stay 1 for two consecutive cycles.
- Gap handling: valid, idle, valid sequence → out_valid pattern 1,0,1. `out` holds its value during the idle cycle.
- Inverse (MIX_COLUMNS_INV_EN defined): inv=1, in=046681e5_e0cb199a_48f8d37a_2806264c → out=d4bf5d30_e0b452ae_b84111f1_1e2798e5. Random forward-then-inverse round trips reproduce the input.
- Mid-stream reset: assert reset in the cycle after an in_valid → out=0 and out_valid=0 on the next edge; the pending result is lost.

Source files
------------

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - registered AES MixColumns stage (optional InvMixColumns via MIX_COLUMNS_INV_EN)

module mix_columns_col (
    input  logic [31:0] col,
`ifdef MIX_COLUMNS_INV_EN
    input  logic        inv,
`endif
    output logic [31:0] res
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] b  [4];
`ifdef MIX_COLUMNS_INV_EN
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a[k]  = col[31-8*k -: 8];
            m2[k] = xtime(a[k]);
            m3[k] = m2[k] ^ a[k];
`ifdef MIX_COLUMNS_INV_EN
            // Inverse multiples share the chained xtime of the forward path.
            m4[k] = xtime(m2[k]);
            m8[k] = xtime(m4[k]);
            m9[k] = m8[k] ^ a[k];
            mb[k] = m8[k] ^ m2[k] ^ a[k];
            md[k] = m8[k] ^ m4[k] ^ a[k];
            me[k] = m8[k] ^ m4[k] ^ m2[k];
`endif
        end
        for (int r = 0; r < 4; r++) begin
`ifdef MIX_COLUMNS_INV_EN
            if (inv)
                b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
            else
                b[r] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`else
            b[r] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`endif
        end
        res = {b[0], b[1], b[2], b[3]};
    end

endmodule

module mix_columns (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [0:127] in,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    output logic [0:127] out
);

    logic [0:127] mixed;

    // Column c occupies in[32c:32c+31], row 0 in the most significant byte.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] col_in;
        logic [31:0] col_out;

        assign col_in = in[32*c +: 32];

        mix_columns_col u_col (
            .col (col_in),
`ifdef MIX_COLUMNS_INV_EN
            .inv (inv),
`endif
            .res (col_out)
        );

        assign mixed[32*c +: 32] = col_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= mixed;
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// tb/tb_mix_columns.sv - self-checking bench for mix_columns against a GF(2^8) matrix model

module tb_mix_columns;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [0:127] din;
    logic         out_valid;
    logic [0:127] dout;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (din),
`ifdef MIX_COLUMNS_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out       (dout)
    );

    // Full polynomial product reduced modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (15'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [0:127] ref_mix(input logic [0:127] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [0:127] o;
        if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - r + 4) % 4], s[32*c + 8*k +: 8]);
                o[32*c + 8*r +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = rand128();
            tick();
            checks++;
            if (dout !== 128'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold out=%h valid=%b exp out=0 valid=0", dout, out_valid);
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle valid=%b exp 0", out_valid);
        end
        in_valid = 1'b1;
        din = rand128();
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== ref_mix(din, 1'b0)) begin
            errors++;
            $display("FAIL reset_first valid=%b out=%h exp 1 %h", out_valid, dout, ref_mix(din, 1'b0));
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fips_vector();
        in_valid = 1'b1;
        din = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dout !== 128'h046681e5_e0cb199a_48f8d37a_2806264c) begin
            errors++;
            $display("FAIL fips_round1 valid=%b out=%h exp 1 046681e5e0cb199a48f8d37a2806264c", out_valid, dout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [0:127] vin  [2];
        logic [0:127] vexp [2];
        vin[0]  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vexp[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vin[1]  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        vexp[1] = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = vin[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || dout !== vexp[i]) begin
                errors++;
                $display("FAIL b2b_std%0d valid=%b out=%h exp 1 %h", i, out_valid, dout, vexp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_gap();
        logic [0:127] a;
        logic [0:127] b;
        a = rand128();
        b = rand128();
        in_valid = 1'b1;
        din = a;
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== ref_mix(a, 1'b0)) begin
            errors++;
            $display("FAIL gap_first valid=%b out=%h exp 1 %h", out_valid, dout, ref_mix(a, 1'b0));
        end
        in_valid = 1'b0;
        din = b;
        tick();
        checks++;
        if (out_valid !== 1'b0 || dout !== ref_mix(a, 1'b0)) begin
            errors++;
            $display("FAIL gap_hold valid=%b out=%h exp 0 %h", out_valid, dout, ref_mix(a, 1'b0));
        end
        in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== ref_mix(b, 1'b0)) begin
            errors++;
            $display("FAIL gap_second valid=%b out=%h exp 1 %h", out_valid, dout, ref_mix(b, 1'b0));
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [0:127] x;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = rand128();
            din = x;
            tick();
            checks++;
            if (out_valid !== 1'b1 || dout !== ref_mix(x, 1'b0)) begin
                errors++;
                $display("FAIL random%0d valid=%b out=%h exp 1 %h", i, out_valid, dout, ref_mix(x, 1'b0));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inverse();
        logic [0:127] x;
        logic [0:127] y;
        in_valid = 1'b1;
        inv = 1'b1;
        din = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5) begin
            errors++;
            $display("FAIL inv_fips valid=%b out=%h exp 1 d4bf5d30e0b452aeb84111f11e2798e5", out_valid, dout);
        end
        for (int i = 0; i < 20; i++) begin
            x = rand128();
            inv = 1'b0;
            din = x;
            tick();
            y = dout;
            checks++;
            if (y !== ref_mix(x, 1'b0)) begin
                errors++;
                $display("FAIL rt_fwd%0d out=%h exp %h", i, y, ref_mix(x, 1'b0));
            end
            inv = 1'b1;
            din = y;
            tick();
            checks++;
            if (out_valid !== 1'b1 || dout !== x) begin
                errors++;
                $display("FAIL rt_inv%0d valid=%b out=%h exp 1 %h", i, out_valid, dout, x);
            end
        end
        inv = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_midstream_reset();
        in_valid = 1'b1;
        din = rand128();
        tick();
        reset = 1'b1;
        din = rand128();
        tick();
        checks++;
        if (out_valid !== 1'b0 || dout !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset valid=%b out=%h exp 0 0", out_valid, dout);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || dout !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_after valid=%b out=%h exp 0 0", out_valid, dout);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        din = '0;
`ifdef MIX_COLUMNS_INV_EN
        inv = 1'b0;
`endif
        test_reset();
        test_fips_vector();
        test_back_to_back();
        test_gap();
        test_random();
`ifdef MIX_COLUMNS_INV_EN
        test_inverse();
`endif
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
